qspi_flash_responder: RTL and testbench

- Synthesizable QSPI target that emulates the external storage flash behind the MMU's QSPI master; replaces the pin-level stub in full-system simulation and FPGA bring-up.
- Oversamples the incoming SPI clock in the system clock domain, decodes quad-mode read and program commands, and serves data from an internal byte array.
- Includes a backdoor load port so benches can preload program images.

---
 rtl/qspi_flash_responder.sv | 214 +++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_responder.sv
// Quad-SPI flash target emulator: oversamples the SPI pins in the clk domain and
// serves quad read (EB) / quad program (32) from an internal byte array with a backdoor load port.
`timescale 1ns/1ps
module qspi_flash_responder #(
  parameter int         MEM_BYTES    = 4096,
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_READ     = 8'hEB,
  parameter logic [7:0] CMD_PROG     = 8'h32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         qspi_ck_i,
  input  logic                         qspi_cs_i,
  input  logic [3:0]                   qspi_io_i,
  output logic [3:0]                   qspi_io_o,
  output logic [3:0]                   qspi_io_t,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr_i,
  input  logic [7:0]                   load_data_i,
  output logic                         busy_o,
  output logic                         cmd_err_o
);

  localparam int         AW         = $clog2(MEM_BYTES);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  state_t        state_q;
  logic          ck_s1_q, ck_s2_q, ck_prev_q;
  logic          cs_s1_q, cs_s2_q;
  logic [3:0]    io_s1_q, io_s2_q;
  logic [3:0]    io_o_q, io_t_q;
  logic          cmd_err_q;
  logic          is_read_q;
  logic [2:0]    nib_cnt_q;
  logic [7:0]    dummy_cnt_q;
  logic          half_q;
  logic [3:0]    op_hi_q;
  logic [3:0]    wnib_q;
  logic [AW-1:0] addr_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    mem_q [MEM_BYTES];
  logic          rise_s, fall_s;
  logic [7:0]    rd_byte_s;

  // Pin synchronizers; cs resets to its inactive (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s1_q   <= 1'b0;
      ck_s2_q   <= 1'b0;
      ck_prev_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      io_s1_q   <= 4'h0;
      io_s2_q   <= 4'h0;
    end else begin
      ck_s1_q   <= qspi_ck_i;
      ck_s2_q   <= ck_s1_q;
      ck_prev_q <= ck_s2_q;
      cs_s1_q   <= qspi_cs_i;
      cs_s2_q   <= cs_s1_q;
      io_s1_q   <= qspi_io_i;
      io_s2_q   <= io_s1_q;
    end
  end

  assign rise_s    = ck_s2_q & ~ck_prev_q;
  assign fall_s    = ~ck_s2_q & ck_prev_q;
  assign rd_byte_s = mem_q[addr_q];

  // Protocol FSM; a synchronized CS high overrides everything, including ck edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      io_o_q      <= 4'h0;
      io_t_q      <= 4'hF;
      cmd_err_q   <= 1'b0;
      is_read_q   <= 1'b0;
      nib_cnt_q   <= 3'd0;
      dummy_cnt_q <= 8'd0;
      half_q      <= 1'b0;
      op_hi_q     <= 4'h0;
      wnib_q      <= 4'h0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      cmd_err_q <= 1'b0;
      wr_en_q   <= 1'b0;
      if (cs_s2_q) begin
        state_q     <= ST_IDLE;
        io_o_q      <= 4'h0;
        io_t_q      <= 4'hF;
        nib_cnt_q   <= 3'd0;
        dummy_cnt_q <= 8'd0;
        half_q      <= 1'b0;
        addr_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_CMD;
            nib_cnt_q <= 3'd0;
          end
          ST_CMD: begin
            if (rise_s) begin
              if (nib_cnt_q == 3'd0) begin
                op_hi_q   <= io_s2_q;
                nib_cnt_q <= 3'd1;
              end else begin
                nib_cnt_q <= 3'd0;
                if ({op_hi_q, io_s2_q} == CMD_READ) begin
                  state_q   <= ST_ADDR;
                  is_read_q <= 1'b1;
                end else if ({op_hi_q, io_s2_q} == CMD_PROG) begin
                  state_q   <= ST_ADDR;
                  is_read_q <= 1'b0;
                end else begin
                  state_q   <= ST_IGNORE;
                  cmd_err_q <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (rise_s) begin
              // Shifting through an AW-bit register drops the unused upper address bits
              addr_q <= {addr_q[AW-5:0], io_s2_q};
              if (nib_cnt_q == 3'd5) begin
                nib_cnt_q   <= 3'd0;
                half_q      <= 1'b0;
                dummy_cnt_q <= 8'd0;
                if (!is_read_q) begin
                  state_q <= ST_WDATA;
                end else if (DUMMY_CYCLES == 0) begin
                  state_q <= ST_RDATA;
                end else begin
                  state_q <= ST_DUMMY;
                end
              end else begin
                nib_cnt_q <= nib_cnt_q + 3'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (rise_s) begin
              if (dummy_cnt_q == DUMMY_LAST) begin
                state_q     <= ST_RDATA;
                dummy_cnt_q <= 8'd0;
              end else begin
                dummy_cnt_q <= dummy_cnt_q + 8'd1;
              end
            end
          end
          ST_RDATA: begin
            if (fall_s) begin
              io_t_q <= 4'h0;
              if (!half_q) begin
                io_o_q <= rd_byte_s[7:4];
                half_q <= 1'b1;
              end else begin
                io_o_q <= rd_byte_s[3:0];
                half_q <= 1'b0;
                addr_q <= addr_q + AW'(1);
              end
            end
          end
          ST_WDATA: begin
            if (rise_s) begin
              if (!half_q) begin
                wnib_q <= io_s2_q;
                half_q <= 1'b1;
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= {wnib_q, io_s2_q};
                half_q    <= 1'b0;
                addr_q    <= addr_q + AW'(1);
              end
            end
          end
          ST_IGNORE: begin
            io_t_q <= 4'hF;
          end
          default: begin
            state_q <= ST_IDLE;
            io_t_q  <= 4'hF;
          end
        endcase
      end
    end
  end

  // Array write port; the QSPI write is ordered last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
    if (wr_en_q) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign qspi_io_o = io_o_q;
  assign qspi_io_t = io_t_q;
  assign busy_o    = ~cs_s2_q;
  assign cmd_err_o = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a mode-0 quad master drives randomized reads/programs,
// and every sampled nibble is compared against a byte-array model of the flash.
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  localparam int MEM   = 4096;
  localparam int DUMMY = 4;
  localparam int HALF  = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        ck;
  logic        cs;
  logic [3:0]  io_drv;
  logic [3:0]  io_o_w;
  logic [3:0]  io_t_w;
  logic        load_we;
  logic [11:0] load_addr;
  logic [7:0]  load_data;
  logic        busy_w;
  logic        err_w;

  logic [7:0]  model [MEM];
  logic [3:0]  wq [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          err_cnt = 0;

  qspi_flash_responder #(
    .MEM_BYTES   (MEM),
    .DUMMY_CYCLES(DUMMY),
    .CMD_READ    (8'hEB),
    .CMD_PROG    (8'h32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .qspi_ck_i  (ck),
    .qspi_cs_i  (cs),
    .qspi_io_i  (io_drv),
    .qspi_io_o  (io_o_w),
    .qspi_io_t  (io_t_w),
    .load_we_i  (load_we),
    .load_addr_i(load_addr),
    .load_data_i(load_data),
    .busy_o     (busy_w),
    .cmd_err_o  (err_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_w === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = model[(int'(a) + k / 2) % MEM];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic bd_load(input int a, input logic [7:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = 12'(a); load_data = d;
    model[a] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic ck_cycle(input logic [3:0] d, output logic [3:0] o, output logic [3:0] t);
    io_drv = d;
    #HALF;
    ck = 1'b1;
    o = io_o_w;
    t = io_t_w;
    #HALF;
    ck = 1'b0;
  endtask

  task automatic begin_cmd(input logic [7:0] op, input logic [23:0] a);
    logic [3:0]  o, t;
    logic [31:0] word;
    word = {op, a};
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ck_cycle(word[31-4*i -: 4], o, t);
      check("hdr_release", t, 4'hF);
    end
  endtask

  task automatic end_cs();
    #HALF;
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_read(input logic [23:0] a, input int nnib);
    logic [3:0] o, t;
    begin_cmd(8'hEB, a);
    for (int i = 0; i < DUMMY; i++) begin
      ck_cycle(4'h0, o, t);
      check("dummy_release", t, 4'hF);
    end
    for (int k = 0; k < nnib; k++) begin
      ck_cycle(4'h0, o, t);
      check("rd_drive", t, 4'h0);
      check("rd_nib", o, exp_nib(a, k));
    end
  endtask

  task automatic do_prog(input logic [23:0] a);
    logic [3:0] o, t;
    begin_cmd(8'h32, a);
    for (int i = 0; i < wq.size(); i++) begin
      ck_cycle(wq[i], o, t);
      check("wr_release", t, 4'hF);
    end
    for (int j = 0; j < wq.size() / 2; j++)
      model[(int'(a) + j) % MEM] = {wq[2*j], wq[2*j+1]};
  endtask

  initial begin
    logic [3:0]  o, t;
    logic [23:0] a;
    logic [7:0]  op;
    int          e0, n;

    rst = 1'b1; ck = 1'b0; cs = 1'b1; io_drv = 4'h0;
    load_we = 1'b0; load_addr = 12'h000; load_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_io_o", io_o_w, 4'h0);
    check("rst_io_t", io_t_w, 4'hF);
    check("rst_busy", busy_w, 1'b0);
    check("rst_err", err_w, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Fill the whole array so every read has a defined expected value
    load_we = 1'b1;
    for (int i = 0; i < MEM; i++) begin
      load_addr = 12'(i);
      load_data = 8'($urandom);
      model[i]  = load_data;
      @(negedge clk);
    end
    load_we = 1'b0;
    bd_load(16'h010, 8'h11); bd_load(16'h011, 8'h22);
    bd_load(16'h012, 8'h33); bd_load(16'h013, 8'h44);
    bd_load(16'hFFF, 8'hA5); bd_load(16'h000, 8'h3C);

    do_read(24'h000010, 8);
    check("busy_active", busy_w, 1'b1);
    end_cs();
    check("busy_idle", busy_w, 1'b0);

    do_read(24'h000FFF, 4);
    end_cs();

    wq = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB};
    do_prog(24'h000100);
    end_cs();
    do_read(24'h000100, 6);
    end_cs();

    e0 = err_cnt;
    begin_cmd(8'h9F, 24'h000200);
    for (int i = 0; i < 6; i++) begin
      ck_cycle(4'($urandom), o, t);
      check("ignore_release", t, 4'hF);
    end
    end_cs();
    check("err_pulse", err_cnt - e0, 1);
    do_read(24'h000200, 8);
    end_cs();

    do
      op = 8'($urandom);
    while (op == 8'hEB || op == 8'h32);
    e0 = err_cnt;
    begin_cmd(op, 24'($urandom));
    end_cs();
    check("err_pulse_rand", err_cnt - e0, 1);

    a = 24'($urandom);
    do_read(a, 3);
    #HALF;
    check("abort_driving", io_t_w, 4'h0);
    @(negedge clk);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_release", io_t_w, 4'hF);
    repeat (10) @(negedge clk);
    do_read(a, 4);
    end_cs();

    do_read(24'h000010, 2);
    #23;
    rst = 1'b1;
    #1;
    check("rst_mid_io_t", io_t_w, 4'hF);
    check("rst_mid_io_o", io_o_w, 4'h0);
    #20;
    cs = 1'b1;
    #30;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    do_read(24'h000010, 8);
    end_cs();

    for (int it = 0; it < 10; it++) begin
      a = 24'($urandom);
      if ($urandom_range(2, 0) == 0) a[11:0] = 12'hFFE;
      if ($urandom_range(1, 0) == 0) begin
        do_read(a, $urandom_range(10, 1));
        end_cs();
      end else begin
        wq.delete();
        n = $urandom_range(7, 1);
        for (int i = 0; i < n; i++) wq.push_back(4'($urandom));
        do_prog(a);
        end_cs();
        do_read(a, (n / 2) * 2 + 2);
        end_cs();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
